// File: rtl/grid_game.sv
// grid_game: a token moves one cell per accepted move on a GRID_W x GRID_H grid.
// Reaching the goal wins; stepping on a trap, off the grid or out of moves loses.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   move_valid - a move is presented this cycle
//   dir        - 00 up (y+1), 01 right (x+1), 10 down (y-1), 11 left (x-1)
//   result     - 00 playing, 01 win, 10 lose
//   pos_x      - current column
//   pos_y      - current row
//   move_cnt   - moves accepted since reset
// Optional feature: define GRID_GAME_WRAP_EN to make the grid edges wrap
// around instead of losing the game.
module grid_game #(
  parameter int GRID_W    = 4,
  parameter int GRID_H    = 4,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int GOAL_X    = GRID_W - 1,
  parameter int GOAL_Y    = GRID_H - 1,
  parameter int MAX_MOVES = 16,
  parameter logic [GRID_W*GRID_H-1:0] TRAP_MASK = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        move_valid,
  input  logic [1:0]                  dir,
  output logic [1:0]                  result,
  output logic [$clog2(GRID_W)-1:0]   pos_x,
  output logic [$clog2(GRID_H)-1:0]   pos_y,
  output logic [7:0]                  move_cnt
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int N  = GRID_W * GRID_H;

  // One extra bit so x-1 at column 0 and
  // x+1 at the last column land outside
  // the grid instead of aliasing.
  typedef logic [XW:0] xe_t;
  typedef logic [YW:0] ye_t;

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10
  } state_t;

  localparam logic [XW-1:0] SX = START_X[XW-1:0];
  localparam logic [YW-1:0] SY = START_Y[YW-1:0];

  localparam xe_t X1   = xe_t'(1);
  localparam ye_t Y1   = ye_t'(1);
  localparam xe_t XLIM = xe_t'(GRID_W);
  localparam ye_t YLIM = ye_t'(GRID_H);
  localparam xe_t GX   = xe_t'(GOAL_X);
  localparam ye_t GY   = ye_t'(GOAL_Y);

  localparam logic [7:0] MAXC =
    MAX_MOVES[7:0];

`ifdef GRID_GAME_WRAP_EN
  localparam xe_t XMAX = xe_t'(GRID_W - 1);
  localparam ye_t YMAX = ye_t'(GRID_H - 1);
`endif

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [7:0]    r_cnt;

  xe_t           w_xe;
  ye_t           w_ye;
  xe_t           w_nx;
  ye_t           w_ny;
  logic          w_off;
  logic          w_trap;
  logic          w_goal;
  logic          w_budget;
  logic [7:0]    w_cnt_nxt;
  int            w_idx;
  logic [N-1:0]  w_sh;
  logic          w_accept;

  assign w_accept  = move_valid
                   && (r_state == PLAY);
  assign w_cnt_nxt = r_cnt + 8'd1;

  // Candidate cell in widened coordinates.
  always_comb begin
    w_xe  = {1'b0, r_x};
    w_ye  = {1'b0, r_y};
    w_nx  = w_xe;
    w_ny  = w_ye;
    w_off = 1'b0;
    unique case (dir)
      2'b00: w_ny = w_ye + Y1;
      2'b01: w_nx = w_xe + X1;
      2'b10: w_ny = w_ye - Y1;
      2'b11: w_nx = w_xe - X1;
      default: begin
        w_nx = w_xe;
        w_ny = w_ye;
      end
    endcase
`ifdef GRID_GAME_WRAP_EN
    // Underflow shows up as all-ones,
    // which is above the limit.
    if (w_nx == XLIM)
      w_nx = '0;
    else if (w_nx > XLIM)
      w_nx = XMAX;
    if (w_ny == YLIM)
      w_ny = '0;
    else if (w_ny > YLIM)
      w_ny = YMAX;
`else
    w_off = (w_nx >= XLIM)
         || (w_ny >= YLIM);
`endif
  end

  // Trap and goal lookups on the
  // candidate cell; meaningless when
  // the cell is off the grid.
  always_comb begin
    w_idx    = int'(w_ny) * GRID_W
             + int'(w_nx);
    w_sh     = TRAP_MASK >> w_idx;
    w_trap   = !w_off && w_sh[0];
    w_goal   = !w_off
            && (w_nx == GX)
            && (w_ny == GY);
    w_budget = (w_cnt_nxt == MAXC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PLAY;
      r_x     <= SX;
      r_y     <= SY;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_nxt;
      // Off-grid keeps the last valid cell.
      if (!w_off) begin
        r_x <= w_nx[XW-1:0];
        r_y <= w_ny[YW-1:0];
      end
      // Goal outranks running out of moves.
      if (w_off)
        r_state <= LOSE;
      else if (w_trap)
        r_state <= LOSE;
      else if (w_goal)
        r_state <= WIN;
      else if (w_budget)
        r_state <= LOSE;
      else
        r_state <= PLAY;
    end
  end

  assign result   = r_state;
  assign pos_x    = r_x;
  assign pos_y    = r_y;
  assign move_cnt = r_cnt;

endmodule

// File: tb/tb_grid_game.sv
// Testbench for grid_game: four parameterisations share one stimulus stream
// and are checked against a cell-level game model plus fixed expectations.
module tb_grid_game;

  localparam logic [1:0] U = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] D = 2'b10;
  localparam logic [1:0] L = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_valid = 1'b0;
  logic [1:0] dir = 2'b00;

  logic [1:0] res [4];
  logic [1:0] px  [4];
  logic [1:0] py  [4];
  logic [7:0] cnt [4];

  always #5 clk = ~clk;

  grid_game u0 (
    .clk(clk), .reset(reset),
    .move_valid(move_valid), .dir(dir),
    .result(res[0]), .pos_x(px[0]),
    .pos_y(py[0]), .move_cnt(cnt[0])
  );

  grid_game #(
    .TRAP_MASK(16'h0202)
  ) u1 (
    .clk(clk), .reset(reset),
    .move_valid(move_valid), .dir(dir),
    .result(res[1]), .pos_x(px[1]),
    .pos_y(py[1]), .move_cnt(cnt[1])
  );

  grid_game #(
    .MAX_MOVES(4)
  ) u2 (
    .clk(clk), .reset(reset),
    .move_valid(move_valid), .dir(dir),
    .result(res[2]), .pos_x(px[2]),
    .pos_y(py[2]), .move_cnt(cnt[2])
  );

  grid_game #(
    .MAX_MOVES(6)
  ) u3 (
    .clk(clk), .reset(reset),
    .move_valid(move_valid), .dir(dir),
    .result(res[3]), .pos_x(px[3]),
    .pos_y(py[3]), .move_cnt(cnt[3])
  );

  int checks = 0;
  int failures = 0;

  // Game model: plain integer coordinates.
  logic [15:0] tm [4];
  int mm [4];
  int mx [4];
  int my [4];
  int mc [4];
  int mr [4];

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  task automatic model_step(input bit r,
                            input bit mv,
                            input logic [1:0] d);
    int nx;
    int ny;
    bit off;
    logic [15:0] s;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        mx[i] = 0; my[i] = 0;
        mc[i] = 0; mr[i] = 0;
      end else if (mv && mr[i] == 0) begin
        nx = mx[i]; ny = my[i];
        case (d)
          U: ny = ny + 1;
          R: nx = nx + 1;
          D: ny = ny - 1;
          default: nx = nx - 1;
        endcase
`ifdef GRID_GAME_WRAP_EN
        nx = (nx + 4) % 4;
        ny = (ny + 4) % 4;
        off = 1'b0;
`else
        off = nx < 0 || nx > 3
           || ny < 0 || ny > 3;
`endif
        mc[i] = mc[i] + 1;
        if (off) begin
          mr[i] = 2;
        end else begin
          mx[i] = nx; my[i] = ny;
          s = tm[i] >> (ny * 4 + nx);
          if (s[0]) mr[i] = 2;
          else if (nx == 3 && ny == 3)
            mr[i] = 1;
          else if (mc[i] == mm[i])
            mr[i] = 2;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.u%0d.result", tag, i),
            int'(res[i]), mr[i]);
      check($sformatf("%s.u%0d.x", tag, i),
            int'(px[i]), mx[i]);
      check($sformatf("%s.u%0d.y", tag, i),
            int'(py[i]), my[i]);
      check($sformatf("%s.u%0d.cnt", tag, i),
            int'(cnt[i]), mc[i]);
    end
  endtask

  // Apply one cycle, advance model, sample.
  task automatic step(input bit r,
                      input bit mv,
                      input logic [1:0] d);
    reset = r;
    move_valid = mv;
    dir = d;
    @(posedge clk);
    #1;
    model_step(r, mv, d);
  endtask

  task automatic check_u(input string nm,
                         input int i,
                         input int er,
                         input int ex,
                         input int ey,
                         input int ec);
    check({nm, ".result"}, int'(res[i]), er);
    check({nm, ".x"}, int'(px[i]), ex);
    check({nm, ".y"}, int'(py[i]), ey);
    check({nm, ".cnt"}, int'(cnt[i]), ec);
  endtask

  typedef struct {
    bit         r;
    bit         mv;
    logic [1:0] d;
    int         er;
    int         ex;
    int         ey;
    int         ec;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tm[0] = 16'h0000; mm[0] = 16;
    tm[1] = 16'h0202; mm[1] = 16;
    tm[2] = 16'h0000; mm[2] = 4;
    tm[3] = 16'h0000; mm[3] = 6;
    for (int i = 0; i < 4; i++) begin
      mx[i] = 0; my[i] = 0;
      mc[i] = 0; mr[i] = 0;
    end

    // Default-grid win path, freeze,
    // reset out of WIN, then bottom edge.
    tbl[0]  = '{1, 0, U, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, R, 0, 1, 0, 1};
    tbl[2]  = '{0, 0, U, 0, 1, 0, 1};
    tbl[3]  = '{0, 1, R, 0, 2, 0, 2};
    tbl[4]  = '{0, 1, R, 0, 3, 0, 3};
    tbl[5]  = '{0, 1, U, 0, 3, 1, 4};
    tbl[6]  = '{0, 1, U, 0, 3, 2, 5};
    tbl[7]  = '{0, 1, U, 1, 3, 3, 6};
    tbl[8]  = '{0, 1, R, 1, 3, 3, 6};
    tbl[9]  = '{0, 1, D, 1, 3, 3, 6};
    tbl[10] = '{1, 1, R, 0, 0, 0, 0};
`ifdef GRID_GAME_WRAP_EN
    tbl[11] = '{0, 1, D, 0, 0, 3, 1};
`else
    tbl[11] = '{0, 1, D, 2, 0, 0, 1};
`endif

    for (int k = 0; k < 12; k++) begin
      step(tbl[k].r, tbl[k].mv, tbl[k].d);
      check_u($sformatf("tbl%0d", k), 0,
              tbl[k].er, tbl[k].ex,
              tbl[k].ey, tbl[k].ec);
      check_model($sformatf("tbl%0d", k));
    end

    // Trap at (1,0) on u1.
    step(1, 0, U);
    step(0, 1, R);
    check_u("trap.u1", 1, 2, 1, 0, 1);
    // Budget of 4 on u2: R,L,R,L.
    step(0, 1, L);
    step(0, 1, R);
    check_u("budget3.u2", 2, 0, 1, 0, 3);
    step(0, 1, L);
    check_u("budget4.u2", 2, 2, 0, 0, 4);
    step(0, 1, R);
    check_u("budgetfrz.u2", 2, 2, 0, 0, 4);
    check_model("budget");

    // Goal on the last budgeted move.
    step(1, 0, U);
    step(0, 1, R);
    step(0, 1, R);
    step(0, 1, R);
    step(0, 1, U);
    step(0, 1, U);
    check_u("last5.u3", 3, 0, 3, 2, 5);
    step(0, 1, U);
    check_u("lastgoal.u3", 3, 1, 3, 3, 6);
    check_u("lastgoal.u2", 2, 2, 3, 1, 4);
    check_model("lastgoal");

    // Idle cycles in PLAY.
    step(1, 0, U);
    step(0, 1, R);
    for (int k = 0; k < 10; k++)
      step(0, 0, $urandom_range(0, 3));
    check_u("idle.u0", 0, 0, 1, 0, 1);
    check_model("idle");

    // Random games against the model.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)));
      check_model($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_game.md
GRID_GAME -- requirements
Module: grid_game

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  GRID_W, 4, grid columns (2..16).
  GRID_H, 4, grid rows (2..16).
  START_X / START_Y, 0 / 0, start cell.
  GOAL_X / GOAL_Y, GRID_W-1 / GRID_H-1, winning cell.
  MAX_MOVES, 16, move budget (1..255).
  TRAP_MASK, 0, GRID_W*GRID_H bits; bit (y*GRID_W+x) set = trap cell.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, input, 1, sole clock, rising edge.
  reset, input, 1, synchronous active-high reset.
  move_valid, input, 1, a move is presented this cycle.
  dir, input, 2, move direction: 00 up (y+1), 01 right (x+1), 10 down (y-1), 11 left (x-1).
  result, output, 2, 00 playing, 01 win, 10 lose; 11 never driven.
  pos_x, output, clog2(GRID_W), current column.
  pos_y, output, clog2(GRID_H), current row.
  move_cnt, output, 8, moves accepted since reset.

Function
REQ-003 FSM states: PLAY, WIN, LOSE; result encodes state directly (PLAY=00, WIN=01, LOSE=10).
REQ-004 Move accepted on a rising edge only when move_valid=1, reset=0 and state=PLAY; all outputs update on that edge (latency 1 cycle).
REQ-005 In PLAY, move_valid=0 leaves every register unchanged.
REQ-006 Per accepted move: move_cnt increments by 1; next cell computed from dir.
REQ-007 Next state evaluated in priority order: off-grid (REQ-013) -> LOSE; next cell trap -> LOSE; next cell goal -> WIN; move_cnt+1 = MAX_MOVES -> LOSE; otherwise PLAY.
REQ-008 Goal reached on the final budgeted move -> WIN (goal outranks budget).
REQ-009 WIN and LOSE are sticky until reset; move_valid ignored; pos_x, pos_y, move_cnt frozen.
REQ-010 Start cell is never evaluated as trap or goal; result stays 00 until first accepted move.
REQ-011 move_cnt never exceeds MAX_MOVES.
REQ-012 Coordinate arithmetic uses unsigned widths one bit wider than pos_x/pos_y so edge checks cannot alias.

Reset
REQ-013 Without wrap (REQ-016), a move leaving the grid (x<0, x>=GRID_W, y<0, y>=GRID_H) -> LOSE; position holds last valid cell; move_cnt still increments.
REQ-014 reset=1 at a rising edge forces state=PLAY, pos=(START_X,START_Y), move_cnt=0, result=00, regardless of move_valid or current state.
REQ-015 reset has priority over a simultaneous move; reset mid-game discards the game; first move accepted on the first edge with reset=0.

Configuration
REQ-016 Macro GRID_GAME_WRAP_EN defined: leaving the grid wraps (x=-1 -> GRID_W-1, x=GRID_W -> 0, same for y); never LOSE for leaving the grid; trap/goal/budget checks apply to the wrapped cell. Not defined: REQ-013 applies.

Verification (defaults unless stated)
REQ-017 Reset, then R,R,R,U,U,U -> result 00 after 5 moves, 01 after 6th; pos=(3,3), move_cnt=6; further moves leave all outputs unchanged.
REQ-018 From (0,0) apply D, macro undefined -> result 10, pos=(0,0), move_cnt=1; macro defined -> result 00, pos=(0,3).
REQ-019 TRAP_MASK bit 1 set: from (0,0) apply R -> result 10, pos=(1,0), move_cnt=1.
REQ-020 MAX_MOVES=4: R,L,R,L -> result 00 after 3 moves, 10 after 4th, move_cnt=4; MAX_MOVES=6 with R,R,R,U,U,U -> 01.
REQ-021 move_valid=0 for 10 cycles in PLAY -> no change; reset=1 with move_valid=1 in WIN -> result 00, pos=(0,0), move_cnt=0.
